// File: rtl/clkgate_pkg.sv
// Shared definitions for the per-domain clock-gating controller:
// channel state encoding and its width.
package clkgate_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ON   = 2'b00,
    ST_WAKE = 2'b01,
    ST_OFF  = 2'b10
  } state_e;

endpackage

// File: rtl/clkgate_ctrl_chan.sv
// One gating channel: idle counter, ON/OFF/WAKE state machine and the
// registered wake acknowledge for a single clock domain.
module clkgate_ctrl_chan
  import clkgate_pkg::*;
#(
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDLE_W-1:0] cfg_idle,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              force_on,
  output logic              wake_ack,
  output logic              gate,
  output logic              gated
);

  localparam logic [IDLE_W-1:0] WAKE_LAST = IDLE_W'(WAKE_CYCLES - 1);

  state_e            r_state;
  logic [IDLE_W-1:0] r_cnt;
  logic              r_gate;
  logic              r_gated;
  logic              r_ack;

  logic              w_act;
  logic [IDLE_W:0]   w_cnt_inc;
  logic              w_idle_hit;
  logic              w_wake_done;
  logic              w_cfg_off;

  // One extra bit on the compare so cnt+1 cannot wrap below the threshold.
  assign w_act       = busy | wake_req | force_on;
  assign w_cnt_inc   = {1'b0, r_cnt} + {{IDLE_W{1'b0}}, 1'b1};
  assign w_idle_hit  = (w_cnt_inc >= {1'b0, cfg_idle});
  assign w_wake_done = (r_cnt == WAKE_LAST);
  assign w_cfg_off   = (cfg_idle == {IDLE_W{1'b0}});

  // Channel state, idle/settle counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ON;
      r_cnt   <= {IDLE_W{1'b0}};
      r_gate  <= 1'b1;
      r_gated <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= wake_req & (r_state == ST_ON);
      case (r_state)
        ST_ON: begin
          if (w_act || w_cfg_off) begin
            r_cnt <= {IDLE_W{1'b0}};
          end else if (w_idle_hit) begin
            r_state <= ST_OFF;
            r_gate  <= 1'b0;
            r_gated <= 1'b1;
            r_cnt   <= {IDLE_W{1'b0}};
          end else begin
            r_cnt <= w_cnt_inc[IDLE_W-1:0];
          end
        end
        ST_OFF: begin
          if (w_act) begin
            r_state <= ST_WAKE;
            r_gate  <= 1'b1;
            r_gated <= 1'b0;
            r_cnt   <= {IDLE_W{1'b0}};
          end else begin
            r_state <= ST_OFF;
          end
        end
        // Settle time cannot be cut short; inputs are ignored until ON.
        ST_WAKE: begin
          if (w_wake_done) begin
            r_state <= ST_ON;
            r_cnt   <= {IDLE_W{1'b0}};
          end else begin
            r_cnt <= w_cnt_inc[IDLE_W-1:0];
          end
        end
        default: begin
          r_state <= ST_ON;
          r_gate  <= 1'b1;
          r_gated <= 1'b0;
          r_cnt   <= {IDLE_W{1'b0}};
        end
      endcase
    end
  end

  assign wake_ack = r_ack;
  assign gate     = r_gate;
  assign gated    = r_gated;

endmodule

// File: rtl/clkgate_ctrl.sv
// Per-domain clock-gating controller: one independent channel per gated
// domain, all sharing the idle threshold. Drives the external clkgate cells.
module clkgate_ctrl
  import clkgate_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDLE_W-1:0] cfg_idle,
  input  logic [N_DOM-1:0]  force_on,
  input  logic [N_DOM-1:0]  busy,
  input  logic [N_DOM-1:0]  wake_req,
  output logic [N_DOM-1:0]  wake_ack,
  output logic [N_DOM-1:0]  gate,
  output logic [N_DOM-1:0]  gated
);

  for (genvar g = 0; g < N_DOM; g++) begin : g_chan
    clkgate_ctrl_chan #(
      .IDLE_W      (IDLE_W),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_idle (cfg_idle),
      .busy     (busy[g]),
      .wake_req (wake_req[g]),
      .force_on (force_on[g]),
      .wake_ack (wake_ack[g]),
      .gate     (gate[g]),
      .gated    (gated[g])
    );
  end

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed scenarios plus randomized traffic for clkgate_ctrl, checked every
// edge against a timeline model of idle runs and settle countdowns.
module tb_clkgate_ctrl;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] cfg_idle;
  logic [N-1:0]  force_on, busy, wake_req;
  logic [N-1:0]  wake_ack, gate, gated;

  int checks = 0;
  int errors = 0;

  // Model: per domain, off flag, remaining settle cycles, idle run length.
  bit m_off  [N];
  int m_wake [N];
  int m_idle [N];
  bit m_ack  [N];

  clkgate_ctrl #(.N_DOM(N), .IDLE_W(IW), .WAKE_CYCLES(WC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_idle (cfg_idle),
    .force_on (force_on),
    .busy     (busy),
    .wake_req (wake_req),
    .wake_ack (wake_ack),
    .gate     (gate),
    .gated    (gated)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_off[c] = 1'b0; m_wake[c] = 0; m_idle[c] = 0; m_ack[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      logic act;
      logic was_on;
      act    = busy[c] | wake_req[c] | force_on[c];
      was_on = !m_off[c] && (m_wake[c] == 0);
      m_ack[c] = wake_req[c] && was_on;
      if (m_wake[c] > 0) begin
        m_wake[c] = m_wake[c] - 1;
        m_idle[c] = 0;
      end else if (m_off[c]) begin
        if (act) begin
          m_off[c]  = 1'b0;
          m_wake[c] = WC;
        end
      end else if (act || cfg_idle == 8'd0) begin
        m_idle[c] = 0;
      end else begin
        m_idle[c] = m_idle[c] + 1;
        if (m_idle[c] >= int'(cfg_idle)) begin
          m_off[c]  = 1'b1;
          m_idle[c] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg, ed, ea;
    for (int c = 0; c < N; c++) begin
      eg[c] = !m_off[c];
      ed[c] = m_off[c];
      ea[c] = m_ack[c];
    end
    chk({tag, ".gate"},  gate,     eg);
    chk({tag, ".gated"}, gated,    ed);
    chk({tag, ".ack"},   wake_ack, ea);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic reset_cycles(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    check_outputs("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    cfg_idle = 8'd3; force_on = 4'b0; busy = 4'b0; wake_req = 4'b0;
    model_reset();

    // Reset release, idle threshold 3: gates close after edge 3.
    reset_cycles(3);
    chk("rst.gate_const", gate, 4'b1111);
    step("idle1"); step("idle2");
    chk("idle2.gate", gate, 4'b1111);
    step("idle3");
    chk("idle3.gate", gate, 4'b0000);
    chk("idle3.gated", gated, 4'b1111);

    // Four-phase wake on channel 0, req raised before edge 10.
    repeat (6) step("pre_wake");
    wake_req[0] = 1'b1;
    step("wk10");
    chk("wk10.gate0", {3'b000, gate[0]}, 4'b0001);
    step("wk11"); step("wk12");
    chk("wk12.ack0", {3'b000, wake_ack[0]}, 4'b0000);
    step("wk13");
    chk("wk13.ack0", {3'b000, wake_ack[0]}, 4'b0001);
    step("wk14");
    wake_req[0] = 1'b0;
    step("wk_drop");
    chk("wk_drop.ack0", {3'b000, wake_ack[0]}, 4'b0000);

    // busy[1] every third cycle keeps the clock on; stop -> close after 4 edges.
    cfg_idle = 8'd4;
    for (int i = 0; i < 30; i++) begin
      busy[1] = (i % 3 == 0);
      step("busy1");
      if (i >= 3) chk("busy1.gate1", {3'b000, gate[1]}, 4'b0001);
    end
    busy[1] = 1'b0;
    step("b_j3");
    chk("b_j3.gate1", {3'b000, gate[1]}, 4'b0001);
    step("b_j4");
    chk("b_j4.gate1", {3'b000, gate[1]}, 4'b0000);

    // Auto-gating disabled for 300 idle cycles, then threshold 1.
    cfg_idle = 8'd0;
    reset_cycles(2);
    repeat (300) step("cfg0");
    chk("cfg0.gate", gate, 4'b1111);
    cfg_idle = 8'd1;
    step("cfg1");
    chk("cfg1.gate", gate, 4'b0000);

    // Threshold lowered from 200 to 5 mid-count.
    cfg_idle = 8'd200;
    reset_cycles(2);
    repeat (50) step("c200");
    chk("c200.gate", gate, 4'b1111);
    cfg_idle = 8'd5;
    step("c5");
    chk("c5.gate", gate, 4'b0000);

    // force_on[2] in OFF, reset asserted mid-WAKE, then held ON.
    force_on[2] = 1'b1;
    step("fo_wake");
    chk("fo_wake.gate2", {1'b0, gate[2], 2'b00}, 4'b0100);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async.gate", gate, 4'b1111);
    chk("async.ack", wake_ack, 4'b0000);
    chk("async.gated", gated, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step("fo_hold");
      chk("fo_hold.gate2", {1'b0, gate[2], 2'b00}, 4'b0100);
    end
    force_on[2] = 1'b0;

    // Randomized traffic honouring the four-phase handshake.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) cfg_idle = IW'($urandom_range(0, 6));
      for (int c = 0; c < N; c++) begin
        busy[c] = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 40) == 0) force_on[c] = ~force_on[c];
        if (!wake_req[c] && !m_ack[c] && $urandom_range(0, 5) == 0) wake_req[c] = 1'b1;
        else if (wake_req[c] && m_ack[c] && $urandom_range(0, 1) == 0) wake_req[c] = 1'b0;
      end
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
